mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative 16-bit multiply/divide unit that sits downstream of the register file.
- Operands come from the two read ports; the result goes back through the write port (wdata/waddr/we).
- Single-issue, fixed latency, start/busy/done handshake; control stalls the PC while busy is high.

Parameters:
- WIDTH, 16, operand and result width
- ADDR_SIZE, 5, destination register address width (matches the 32-entry register file)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  2  operation: 0 MUL (low half), 1 MULH (high half), 2 DIV (quotient), 3 REM (remainder)
- op_signed  in  1  signed operation; ignored unless MULDIV_SIGNED_EN is defined
- a  in  WIDTH  operand A (rd1)
- b  in  WIDTH  operand B (rd2)
- dest  in  ADDR_SIZE  destination register
- busy  out  1  high from the cycle after an accepted start through the DONE cycle
- done  out  1  one-cycle pulse; result is valid in this cycle
- result  out  WIDTH  selected result
- wb_addr  out  ADDR_SIZE  latched dest
- wb_we  out  1  write enable to the register file; identical to done

Behaviour:
- Reset (async, any state): state IDLE; busy, done, wb_we, result, wb_addr and all internal registers cleared to 0. An in-flight operation is discarded and no write occurs.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 latches a, b, op, op_signed and dest, clears the iteration counter, then goes to RUN.
  - RUN: one iteration per cycle for exactly WIDTH cycles, then goes to DONE.
  - DONE: done=wb_we=1 for one cycle, then goes to IDLE.
- Latency: start sampled at edge 0 gives done high during cycle WIDTH+1 (17 cycles at the default).
- Back-to-back: start is accepted again in the IDLE cycle after DONE.
- start, op, a, b and dest are ignored while busy; operands are only sampled at acceptance.
- MUL/MULH: shift-add over a 2*WIDTH product register. MUL returns product[WIDTH-1:0]; MULH returns product[2*WIDTH-1:WIDTH].
- DIV/REM: restoring division over a WIDTH+1-bit partial remainder, with a fixed WIDTH iterations.
- Divide by zero needs no special path: quotient = all ones, remainder = a, same latency.
- result and wb_addr hold their values after DONE until the next accepted start.
- dest = 0 is written like any other address.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined, op_signed=1:
  - Operands are converted to magnitudes before iterating, and results are sign-corrected in DONE, so latency is unchanged.
  - Quotient sign = sign(a) XOR sign(b); remainder takes the sign of a; MULH returns the signed high half.
  - Overflow case: -2^(WIDTH-1) / -1 gives quotient 0x8000, remainder 0.
  - Signed divide by zero: quotient all ones, remainder = a.
- Not defined: op_signed is unused, all operations are unsigned, and no sign logic is synthesised.

Decomposition:
- Package muldiv_pkg:
  - op enum (OP_MUL, OP_MULH, OP_DIV, OP_REM)
  - state enum (ST_IDLE, ST_RUN, ST_DONE)
  - default WIDTH constant
- Sub-module div_step: purely combinational, one restoring-division iteration (partial remainder, dividend bit, divisor → next remainder, quotient bit).
- Everything else stays in mul_div_unit.

Test Plan:
- MUL a=300, b=200 → done at cycle 17, result=0xEA60, wb_addr=dest, wb_we pulse of exactly 1 cycle; repeat with MULH → 0x0000.
- MUL and MULH with a=b=0xFFFF → 0x0001 and 0xFFFE.
- DIV 1000/7 → 0x008E; REM 1000/7 → 0x0006. DIV 1234/0 → 0xFFFF; REM 1234/0 → 0x04D2.
- Accepted MUL 3*4, with start pulsed at cycles 3 and 10 carrying other operands → single done with result 0x000C; no extra wb_we pulse.
- Assert rst during RUN cycle 5 → busy=0, result=0 immediately, no wb_we; a following DIV 9/3 → 0x0003 with normal latency.
- With MULDIV_SIGNED_EN, op_signed=1:
  - DIV -7/2 → 0xFFFD; REM -7/2 → 0xFFFF.
  - DIV 0x8000/0xFFFF → 0x8000; REM → 0x0000.
  - MULH -2*3 → 0xFFFF.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_MUL  = 2'd0,
    OP_MULH = 2'd1,
    OP_DIV  = 2'd2,
    OP_REM  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_div_unit_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             unused_rem_msb;

  // The partial remainder is always below the divisor, so its top bit is never set on entry.
  assign unused_rem_msb = rem_in[WIDTH];
  assign shifted        = {rem_in[WIDTH-1:0], dividend_bit};
  assign diff           = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit          = ~diff[WIDTH+1];
  assign rem_out        = q_bit ? diff[WIDTH:0] : shifted;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with start/busy/done handshake and register-file writeback.
// Optional signed support is enabled by defining MULDIV_SIGNED_EN.
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ADDR_SIZE = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic                 op_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [ADDR_SIZE-1:0] dest,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic [ADDR_SIZE-1:0] wb_addr,
  output logic                 wb_we
);

  localparam int CW = $clog2(WIDTH);

  state_e               state_reg, state_next;
  op_e                  op_reg;
  logic [CW-1:0]        cnt_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [WIDTH-1:0]     quo_reg;
  logic [WIDTH-1:0]     result_reg;
  logic [2*WIDTH-1:0]   prod_reg;
  logic [WIDTH:0]       rem_reg;
  logic [WIDTH:0]       rem_next;
  logic                 q_bit;
  logic [ADDR_SIZE-1:0] wb_addr_reg;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix, final_res;

`ifdef MULDIV_SIGNED_EN
  logic neg_a_reg, neg_b_reg;
  logic a_neg, b_neg;

  assign a_neg = op_signed & a[WIDTH-1];
  assign b_neg = op_signed & b[WIDTH-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;
`else
  logic unused_op_signed;

  assign unused_op_signed = op_signed;
  assign mag_a = a;
  assign mag_b = b;
`endif

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in      (rem_reg),
    .dividend_bit(quo_reg[WIDTH-1]),
    .divisor     (b_reg),
    .rem_out     (rem_next),
    .q_bit       (q_bit)
  );

  // Shift-add: add the multiplicand to the upper half when the current multiplier bit is set.
  assign add_sum = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + (prod_reg[0] ? {1'b0, b_reg} : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (cnt_reg == CW'(WIDTH - 1)) state_next = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg      <= OP_MUL;
      cnt_reg     <= '0;
      b_reg       <= '0;
      quo_reg     <= '0;
      prod_reg    <= '0;
      rem_reg     <= '0;
      result_reg  <= '0;
      wb_addr_reg <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_a_reg   <= 1'b0;
      neg_b_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: if (start) begin
          op_reg      <= op_e'(op);
          cnt_reg     <= '0;
          b_reg       <= mag_b;
          quo_reg     <= mag_a;
          prod_reg    <= {{WIDTH{1'b0}}, mag_a};
          rem_reg     <= '0;
          wb_addr_reg <= dest;
`ifdef MULDIV_SIGNED_EN
          neg_a_reg   <= a_neg;
          neg_b_reg   <= b_neg;
`endif
        end
        ST_RUN: begin
          cnt_reg  <= cnt_reg + 1'b1;
          prod_reg <= {add_sum, prod_reg[WIDTH-1:1]};
          quo_reg  <= {quo_reg[WIDTH-2:0], q_bit};
          rem_reg  <= rem_next;
        end
        ST_DONE: result_reg <= final_res;
        default: ;
      endcase
    end
  end

  // Sign correction happens on the magnitude results while in DONE, keeping latency fixed.
  always_comb begin
    prod_fix = prod_reg;
    quo_fix  = quo_reg;
    rem_fix  = rem_reg[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
    if (neg_a_reg ^ neg_b_reg)                   prod_fix = -prod_reg;
    if ((neg_a_reg ^ neg_b_reg) && (b_reg != '0)) quo_fix  = -quo_reg;
    if (neg_a_reg)                               rem_fix  = -rem_reg[WIDTH-1:0];
`endif
    case (op_reg)
      OP_MUL:  final_res = prod_fix[WIDTH-1:0];
      OP_MULH: final_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV:  final_res = quo_fix;
      OP_REM:  final_res = rem_fix;
      default: final_res = quo_fix;
    endcase
  end

  assign result  = (state_reg == ST_DONE) ? final_res : result_reg;
  assign wb_addr = wb_addr_reg;
  assign wb_we   = done;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random operations against an arithmetic model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic        op_signed = 1'b0;
  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;
  logic [4:0]  dest = 5'd0;
  logic        busy, done, wb_we;
  logic [15:0] result;
  logic [4:0]  wb_addr;

  int total = 0;
  int bad   = 0;

  mul_div_unit #(.WIDTH(16), .ADDR_SIZE(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .op_signed(op_signed),
    .a        (a),
    .b        (b),
    .dest     (dest),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .wb_addr  (wb_addr),
    .wb_we    (wb_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference results from plain integer arithmetic.
  function automatic logic [15:0] model(input logic [1:0] o, input logic [15:0] x,
                                        input logic [15:0] y, input logic s);
    logic [31:0] p;
    int sx, sy, q, r;
    bit sg;
    sg = 1'b0 & s;
`ifdef MULDIV_SIGNED_EN
    sg = s;
`endif
    if (sg) begin
      sx = int'($signed(x));
      sy = int'($signed(y));
    end else begin
      sx = int'({16'd0, x});
      sy = int'({16'd0, y});
    end
    p = 32'(sx * sy);
    if (sy == 0) begin
      q = -1;
      r = sx;
    end else begin
      q = sx / sy;
      r = sx % sy;
    end
    case (o)
      2'd0:    return p[15:0];
      2'd1:    return p[31:16];
      2'd2:    return 16'(q);
      default: return 16'(r);
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] x,
                        input logic [15:0] y, input logic s, input logic [4:0] d,
                        input logic [15:0] exp, input bit inject);
    int n;
    int extra;
    bit got;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; op_signed = s; dest = d;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); a = 16'($urandom); b = 16'($urandom);
    dest = 5'($urandom); op_signed = 1'($urandom);
    n = 1;
    got = 1'b0;
    @(negedge clk);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    while (n < 40) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (inject && (n == 3 || n == 10)) begin
        start = 1'b1; a = 16'($urandom); b = 16'($urandom); dest = 5'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, ".done_seen"}, 32'(got), 32'd1);
    chk({tag, ".latency"}, 32'(n), 32'd17);
    chk({tag, ".result"}, 32'(result), 32'(exp));
    chk({tag, ".wb_addr"}, 32'(wb_addr), 32'(d));
    chk({tag, ".wb_we"}, 32'(wb_we), 32'd1);
    @(negedge clk);
    chk({tag, ".done_low"}, 32'(done), 32'd0);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
    chk({tag, ".hold"}, 32'(result), 32'(exp));
    extra = 0;
    repeat (inject ? 20 : 2) begin
      @(negedge clk);
      if (wb_we) extra++;
    end
    chk({tag, ".extra_we"}, 32'(extra), 32'd0);
  endtask

  initial begin
    int extra;
    logic [1:0]  ro;
    logic [15:0] rx, ry;
    logic        rs;
    logic [4:0]  rd;

    repeat (2) @(negedge clk);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.wb_we", 32'(wb_we), 32'd0);
    chk("reset.result", 32'(result), 32'd0);
    chk("reset.wb_addr", 32'(wb_addr), 32'd0);
    rst = 1'b0;

    run_op("mul300x200", 2'd0, 16'd300, 16'd200, 1'b0, 5'd7, 16'hEA60, 1'b0);
    run_op("mulh300x200", 2'd1, 16'd300, 16'd200, 1'b0, 5'd8, 16'h0000, 1'b0);
    run_op("mul_ffff", 2'd0, 16'hFFFF, 16'hFFFF, 1'b0, 5'd0, 16'h0001, 1'b0);
    run_op("mulh_ffff", 2'd1, 16'hFFFF, 16'hFFFF, 1'b0, 5'd31, 16'hFFFE, 1'b0);
    run_op("div1000_7", 2'd2, 16'd1000, 16'd7, 1'b0, 5'd3, 16'h008E, 1'b0);
    run_op("rem1000_7", 2'd3, 16'd1000, 16'd7, 1'b0, 5'd4, 16'h0006, 1'b0);
    run_op("div_by0", 2'd2, 16'd1234, 16'd0, 1'b0, 5'd5, 16'hFFFF, 1'b0);
    run_op("rem_by0", 2'd3, 16'd1234, 16'd0, 1'b0, 5'd6, 16'h04D2, 1'b0);
    run_op("mul3x4_ignore", 2'd0, 16'd3, 16'd4, 1'b0, 5'd12, 16'h000C, 1'b1);

    // Reset in the middle of a run discards it.
    @(negedge clk);
    start = 1'b1; op = 2'd2; a = 16'd100; b = 16'd7; op_signed = 1'b0; dest = 5'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.result", 32'(result), 32'd0);
    chk("midrst.wb_we", 32'(wb_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (wb_we) extra++;
    end
    chk("midrst.no_write", 32'(extra), 32'd0);
    run_op("div9_3", 2'd2, 16'd9, 16'd3, 1'b0, 5'd10, 16'h0003, 1'b0);

`ifdef MULDIV_SIGNED_EN
    run_op("sdiv-7_2", 2'd2, 16'hFFF9, 16'd2, 1'b1, 5'd1, 16'hFFFD, 1'b0);
    run_op("srem-7_2", 2'd3, 16'hFFF9, 16'd2, 1'b1, 5'd2, 16'hFFFF, 1'b0);
    run_op("sdiv_ovf", 2'd2, 16'h8000, 16'hFFFF, 1'b1, 5'd3, 16'h8000, 1'b0);
    run_op("srem_ovf", 2'd3, 16'h8000, 16'hFFFF, 1'b1, 5'd4, 16'h0000, 1'b0);
    run_op("smulh-2x3", 2'd1, 16'hFFFE, 16'd3, 1'b1, 5'd5, 16'hFFFF, 1'b0);
    run_op("sdiv_by0", 2'd2, 16'hFF00, 16'd0, 1'b1, 5'd6, 16'hFFFF, 1'b0);
    run_op("srem_by0", 2'd3, 16'hFF00, 16'd0, 1'b1, 5'd7, 16'hFF00, 1'b0);
`endif

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = 16'($urandom);
      ry = (i % 6 == 0) ? 16'd0 : 16'($urandom);
      rs = 1'($urandom);
      rd = 5'($urandom);
      run_op($sformatf("rand%0d", i), ro, rx, ry, rs, rd, model(ro, rx, ry, rs), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
